vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

VGA timing generator and pixel output stage for the invaders display path. It divides `Clk` down to a pixel-rate enable and runs the horizontal/vertical counters that drive the pixel drawer (`CounterX`, `CounterY`, `inDisplayArea`). It registers the drawer's combinational R/G/B together with the H/V sync pulses so colour and sync reach the connector aligned. It also emits a once-per-frame tick that game logic uses to update positions during vertical blanking.

## Interface
Parameters:
- `CLK_DIV`, 2: `Clk` cycles per pixel; must be ≥1.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `R`, `G`, `B`  in  1 each  combinational colour from the drawer for the current `CounterX`/`CounterY`.
- `CounterX`  out  10  current pixel column, 0..H_TOTAL-1.
- `CounterY`  out  10  current line, 0..V_TOTAL-1.
- `inDisplayArea`  out  1  combinational: `CounterX` < H_VISIBLE and `CounterY` < V_VISIBLE.
- `PixelEn`  out  1  one-`Clk` pulse per pixel period.
- `vga_h_sync`, `vga_v_sync`  out  1 each  registered, active-low sync.
- `vga_r`, `vga_g`, `vga_b`  out  1 each  registered, blanked colour.
- `FrameTick`  out  1  one-`Clk` pulse at entry to vertical blanking.

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024 so they fit the 10-bit counters.
- Pixel divider:
  - counter `div` runs 0..CLK_DIV-1 and wraps to 0.
  - `PixelEn` = registered (`div` == CLK_DIV-1), so it is high exactly 1 cycle in CLK_DIV.
  - With CLK_DIV=1, `PixelEn` stays high continuously after reset release.
- On each `Clk` edge with `PixelEn`=1:
  - `CounterX` increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, `CounterY` increments; at V_TOTAL-1 it wraps to 0.
- Output stage, also on `PixelEn` cycles only, sampling the pre-update counter values:
  - `vga_r` <= `R` & `inDisplayArea`; likewise `vga_g`, `vga_b`.
  - `vga_h_sync` <= ~(H_VISIBLE+H_FRONT ≤ `CounterX` < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for X 656..751.
  - `vga_v_sync` <= ~(V_VISIBLE+V_FRONT ≤ `CounterY` < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for Y 490..491.
- `FrameTick`: registered, high for exactly the one `Clk` cycle after the counters advance from (H_TOTAL-1, V_VISIBLE-1) to (0, V_VISIBLE). Otherwise 0.
- Counter arithmetic is unsigned 10-bit. Comparisons use constants widened to 11 bits, so sums cannot overflow.

## Timing
- Reset values (asynchronous, while `Reset_n`=0):
  - `div`=0, `CounterX`=0, `CounterY`=0.
  - `PixelEn`=0, `FrameTick`=0.
  - `vga_h_sync`=1, `vga_v_sync`=1.
  - `vga_r`/`vga_g`/`vga_b`=0.
- First `PixelEn` pulse: CLK_DIV cycles after the first rising edge with `Reset_n`=1.
- Latency:
  - Colour and sync for pixel (X,Y) appear at the outputs one pixel period after (X,Y) is presented on the counters.
  - Colour and sync are mutually aligned.
- Outputs hold between `PixelEn` pulses.
- Reset asserted mid-frame: all state returns to reset values immediately; the next frame restarts at (0,0) with no partial sync pulse.
- Simultaneous H and V wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to (0,0) on the same edge.

## Structure
- Package `vga_timing_pkg` holds:
  - the eight default timing constants;
  - derived H_TOTAL/V_TOTAL;
  - sync-window start/end constants.
- Sub-module `pixel_tick_gen` contains the `div` counter and `PixelEn` register, parameterised by CLK_DIV.
- Counters, sync logic, colour registers and `FrameTick` live in the top module.

## Test plan
- Reset: hold `Reset_n`=0 for 5 cycles → all outputs at the reset values listed above; release → first `PixelEn` on the 2nd edge, then every 2nd cycle.
- Line wrap: run 800 `PixelEn` pulses from reset → `CounterX` reads 799 then 0, and `CounterY` steps 0→1 on the same edge.
- H sync: over one line → `vga_h_sync` is low for exactly 96 pixel periods, first low in the period after `CounterX`=656.
- V sync and frame:
  - over one frame (840000 `Clk` cycles) → `vga_v_sync` is low for exactly 2×800 pixel periods.
  - `FrameTick` pulses exactly once, 1 cycle wide, when `CounterY` becomes 480.
- Blanking: hold `R`=`G`=`B`=1 → `vga_r` is 1 for output of X 0..639 and 0 for X 640..799; all colour outputs are 0 for lines 480..524.
- Mid-frame reset: assert `Reset_n`=0 at (X=300,Y=200) → counters read 0 at once and syncs go high; after release, counting restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants for the invaders VGA display path.
// Holds the default 640x480@60 timing figures, the derived line/frame
// totals, the sync-window boundaries, and a small helper that tests
// whether a 10-bit counter value lies inside a half-open window.
// No ports: this is a package imported by vga_sync_gen and pixel_tick_gen.
package vga_timing_pkg;

    // Default pixel clock divider and timing figures
    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Derived totals; both must stay at or below 1024 for the 10-bit counters
    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows are [start, end) in pixels or lines
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // True when lo <= pos < hi; pos is widened to 11 bits so the window
    // bounds can reach 1024 without wrapping.
    function automatic logic inWindow(input logic [9:0]  pos,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen
// Divides the system clock down to a one-cycle pixel-rate enable.
// Ports:
//   Clk      in  system clock
//   Reset_n  in  asynchronous active-low reset
//   PixelEn  out one-Clk pulse every CLK_DIV cycles (constant 1 when CLK_DIV=1)
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic PixelEn
);

    // A one-bit counter is kept even for CLK_DIV=1 so the logic stays legal;
    // it then sits at zero and the enable is permanently asserted.
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Free-running divider; the enable is registered from the terminal count
    // so the first pulse lands CLK_DIV edges after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div     <= '0;
            PixelEn <= 1'b0;
        end else begin
            PixelEn <= (div == DIV_LAST);
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// VGA timing generator and registered pixel output stage.
// Ports:
//   Clk, Reset_n               clock, asynchronous active-low reset
//   R, G, B                    drawer colour for the current CounterX/CounterY
//   CounterX, CounterY         current pixel column / line
//   inDisplayArea              combinational visible-area flag
//   PixelEn                    one-Clk pulse per pixel period
//   vga_h_sync, vga_v_sync     registered active-low syncs
//   vga_r, vga_g, vga_b        registered, blanked colour
//   FrameTick                  one-Clk pulse on entry to vertical blanking
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       R,
    input  logic       G,
    input  logic       B,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       inDisplayArea,
    output logic       PixelEn,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       FrameTick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // All comparison constants are 11 bits wide so a 1024 total cannot wrap
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0] V_TICK    = 11'(V_VISIBLE - 1);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] xWide;
    logic [10:0] yWide;
    logic        xAtEnd;
    logic        yAtEnd;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) uTick (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .PixelEn (PixelEn)
    );

    assign xWide         = {1'b0, CounterX};
    assign yWide         = {1'b0, CounterY};
    assign xAtEnd        = (xWide == H_LAST);
    assign yAtEnd        = (yWide == V_LAST);
    assign inDisplayArea = (xWide < H_VIS) && (yWide < V_VIS);

    // Raster counters: X steps every pixel, Y steps on the X wrap, and the
    // last pixel of the last line returns both to (0,0) on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            CounterX <= '0;
            CounterY <= '0;
        end else if (PixelEn) begin
            if (xAtEnd) begin
                CounterX <= '0;
                if (yAtEnd) begin
                    CounterY <= '0;
                end else begin
                    CounterY <= CounterY + 10'd1;
                end
            end else begin
                CounterX <= CounterX + 10'd1;
            end
        end
    end

    // Output stage samples the pre-update counters, so colour and sync both
    // describe the same pixel and appear one pixel period after it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vga_r      <= 1'b0;
            vga_g      <= 1'b0;
            vga_b      <= 1'b0;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else if (PixelEn) begin
            vga_r      <= R & inDisplayArea;
            vga_g      <= G & inDisplayArea;
            vga_b      <= B & inDisplayArea;
            vga_h_sync <= ~inWindow(CounterX, HS_START, HS_END);
            vga_v_sync <= ~inWindow(CounterY, VS_START, VS_END);
        end
    end

    // Frame tick fires for the single cycle after the raster steps from the
    // last visible pixel into the first blanking line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= PixelEn && xAtEnd && (yWide == V_TICK);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Self-checking bench for vga_sync_gen. Uses the full 800-pixel line with a
// shortened vertical frame so whole frames fit in a short run. Expected
// outputs come from the global pixel count since reset release.
module tb_vga_sync_gen;

    localparam int DIV   = 2;
    localparam int HV    = 640;
    localparam int HF    = 16;
    localparam int HS    = 96;
    localparam int HB    = 48;
    localparam int VV    = 12;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 3;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       Clk;
    logic       Reset_n;
    logic       R;
    logic       G;
    logic       B;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic       inDisplayArea;
    logic       PixelEn;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;
    logic       FrameTick;

    // Registered output bundle; r is the MSB, vs the LSB
    typedef struct packed {
        logic r;
        logic g;
        logic b;
        logic hs;
        logic vs;
    } pixOutT;

    localparam pixOutT RESET_OUT = 5'b00011;

    pixOutT expQ[$];
    pixOutT lastExp;
    logic   lastPe;
    int     edgeCount;
    int     checks;
    int     failures;
    int     ftCount;
    int     hsLowCount;
    int     vsLowCount;
    int     monPos;

    vga_sync_gen #(
        .CLK_DIV   (DIV),
        .H_VISIBLE (HV),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .R             (R),
        .G             (G),
        .B             (B),
        .CounterX      (CounterX),
        .CounterY      (CounterY),
        .inDisplayArea (inDisplayArea),
        .PixelEn       (PixelEn),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .FrameTick     (FrameTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pixels fully advanced after edge n (n counted from reset release)
    function automatic int pixAt(input int n);
        return (n > 0) ? (n - 1) / DIV : 0;
    endfunction

    // Enable is high after every DIV-th edge
    function automatic bit expPe(input int n);
        return (n > 0) && (n % DIV == 0);
    endfunction

    // Tick after the advancing edge that lands on the first blanking line
    function automatic bit expTick(input int n);
        return (n >= 2) && ((n - 1) % DIV == 0) && (pixAt(n) % FRAME == VV * HT);
    endfunction

    // What the connector should show for raster position pos with drawer colour
    function automatic pixOutT pixelOut(input int pos, input logic r, input logic g,
                                        input logic b);
        pixOutT o;
        int     x;
        int     y;
        bit     vis;
        x    = pos % HT;
        y    = pos / HT;
        vis  = (x < HV) && (y < VV);
        o.r  = r && vis;
        o.g  = g && vis;
        o.b  = b && vis;
        o.hs = !((x >= HV + HF) && (x < HV + HF + HS));
        o.vs = !((y >= VV + VF) && (y < VV + VF + VS));
        return o;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected,
                     $time);
        end
    endtask

    // One clock of stimulus: count the edge, drive fresh random colour, and
    // queue the expected output when the next edge is a sampling edge.
    task automatic applyStimulus();
        @(posedge Clk);
        if (Reset_n) edgeCount++;
        #1;
        R = 1'($urandom_range(0, 1));
        G = 1'($urandom_range(0, 1));
        B = 1'($urandom_range(0, 1));
        if (expPe(edgeCount)) begin
            expQ.push_back(pixelOut(pixAt(edgeCount) % FRAME, R, G, B));
        end
    endtask

    // Monitor: per-cycle raster checks against the model, and a scoreboard
    // pop whenever the DUT has just taken a pixel-enable edge.
    always @(negedge Clk) begin
        monPos = pixAt(edgeCount) % FRAME;
        checkOutput("CounterX", int'(CounterX), monPos % HT);
        checkOutput("CounterY", int'(CounterY), monPos / HT);
        checkOutput("inDisplayArea", int'(inDisplayArea),
                    int'((monPos % HT < HV) && (monPos / HT < VV)));
        checkOutput("PixelEn", int'(PixelEn), int'(expPe(edgeCount)));
        checkOutput("FrameTick", int'(FrameTick), int'(expTick(edgeCount)));
        if (Reset_n && lastPe) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboardEmpty: got output with no queued entry, expected none (t=%0t)",
                         $time);
            end else begin
                lastExp = expQ.pop_front();
            end
            if (!vga_h_sync) hsLowCount++;
            if (!vga_v_sync) vsLowCount++;
        end
        checkOutput("vga_r", int'(vga_r), int'(lastExp.r));
        checkOutput("vga_g", int'(vga_g), int'(lastExp.g));
        checkOutput("vga_b", int'(vga_b), int'(lastExp.b));
        checkOutput("vga_h_sync", int'(vga_h_sync), int'(lastExp.hs));
        checkOutput("vga_v_sync", int'(vga_v_sync), int'(lastExp.vs));
        if (FrameTick) ftCount++;
        lastPe = PixelEn;
    end

    initial begin
        Reset_n    = 1'b0;
        R          = 1'b0;
        G          = 1'b0;
        B          = 1'b0;
        edgeCount  = 0;
        checks     = 0;
        failures   = 0;
        ftCount    = 0;
        hsLowCount = 0;
        vsLowCount = 0;
        lastPe     = 1'b0;
        lastExp    = RESET_OUT;

        $display("[TB] reset held for 5 cycles");
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        #2;
        Reset_n = 1'b1;

        $display("[TB] running to mid-frame position (300,5)");
        while (pixAt(edgeCount) < 5 * HT + 300) applyStimulus();
        checkOutput("preResetX", int'(CounterX), 300);
        checkOutput("preResetY", int'(CounterY), 5);

        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("asyncResetX", int'(CounterX), 0);
        checkOutput("asyncResetY", int'(CounterY), 0);
        checkOutput("asyncResetHs", int'(vga_h_sync), 1);
        checkOutput("asyncResetVs", int'(vga_v_sync), 1);
        checkOutput("asyncResetRgb", int'({vga_r, vga_g, vga_b}), 0);
        checkOutput("asyncResetPe", int'(PixelEn), 0);
        checkOutput("asyncResetTick", int'(FrameTick), 0);
        expQ.delete();
        lastExp    = RESET_OUT;
        edgeCount  = 0;
        ftCount    = 0;
        hsLowCount = 0;
        vsLowCount = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #2;
        Reset_n = 1'b1;

        $display("[TB] running one full frame plus part of the next");
        while (pixAt(edgeCount) < FRAME + 400) applyStimulus();
        @(negedge Clk);
        #1;
        checkOutput("pendingQueue", expQ.size(), 0);
        checkOutput("frameTickCount", ftCount, 1);
        checkOutput("hSyncLowPeriods", hsLowCount, HS * VT);
        checkOutput("vSyncLowPeriods", vsLowCount, VS * HT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
